lsu_seq: RTL

LSU_SEQ -- requirements
Module: lsu_seq

---
 rtl/lsu_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_seq.sv
// Load/store sequencer: turns one pipeline memory op into 1..4 bus beats on a
// BUS_BYTES-wide port. It assembles load data little-endian, then extracts and
// extends it. Non-memory ops pass through to writeback one cycle after accept.

// Per-beat load capture lane: holds one bus-width slice of the load word.
// m is the forwarded view, so the final beat can be used in the cycle it arrives.
module lsu_seq_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap,
  input  logic [W-1:0] d,
  output logic [W-1:0] m
);
  logic [W-1:0] q;

  // Capture the returned beat for this lane.
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (cap) q <= d;
  end

  assign m = cap ? d : q;
endmodule

module lsu_seq #(
  parameter int XLEN      = 32,
  parameter int BUS_BYTES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic [2:0]             funct3,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [XLEN-1:0]        wdata_i,
  input  logic [XLEN-1:0]        rd_data_i,
  input  logic [4:0]             rd_addr_i,
  input  logic                   rd_we_i,
  output logic                   wb_valid,
  output logic [XLEN-1:0]        rd_data_o,
  output logic [4:0]             rd_addr_o,
  output logic                   rd_we_o,
  output logic                   exc_misalign,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [8*BUS_BYTES-1:0] mem_wdata,
  output logic [BUS_BYTES-1:0]   mem_be,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [8*BUS_BYTES-1:0] mem_rdata
);
  localparam int BW    = 8*BUS_BYTES;
  localparam int NB    = (XLEN/8)/BUS_BYTES;   // max beats for a full word
  localparam int LG    = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 0;
  localparam int OFF_W = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;
  localparam logic [2:0]        BB3   = 3'(BUS_BYTES);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(BUS_BYTES-1);
  localparam logic [ADDR_W-1:0] ABB   = ADDR_W'(BUS_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic [1:0]       beat, last_beat;
  logic [OFF_W-1:0] off_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_addr_q;
  logic             rd_we_q;
  logic [XLEN-1:0]  wd_sh;        // store data, pre-shifted; low BW bits = current beat

  // decode of the presented instruction
  logic             is_mem, mis;
  logic [2:0]       sz;
  logic [OFF_W-1:0] off_i;
  logic [7:0]       be8;
  logic [1:0]       nb_last;

  // Size, alignment, lane offset and beat count of the incoming access.
  always_comb begin
    is_mem = is_load ^ is_store;
    case (funct3[1:0])
      2'b00:   sz = 3'd1;
      2'b01:   sz = 3'd2;
      default: sz = 3'd4;
    endcase
    mis     = (funct3[1:0] == 2'b01 && addr_i[0]) ||
              (funct3[1] && addr_i[1:0] != 2'b00);
    off_i   = '0;
    if (BUS_BYTES > 1) off_i = addr_i[OFF_W-1:0];
    be8     = ((8'd1 << sz) - 8'd1) << off_i;
    nb_last = (sz > BB3) ? 2'((sz >> LG) - 3'd1) : 2'd0;
  end

  assign in_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_wdata = wd_sh[BW-1:0];

  // load assembly: one lane per possible beat
  logic                     rcap;
  logic [NB-1:0][BW-1:0]    lane_m;
  logic [XLEN-1:0]          ld_raw, ld_sh, ld_ext;

  assign rcap = (state == WAIT) & mem_rvalid;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    lsu_seq_lane #(.W(BW)) u_lane (
      .clk (clk),
      .rst (rst),
      .cap (rcap && beat == 2'(g)),
      .d   (mem_rdata),
      .m   (lane_m[g])
    );
  end

  assign ld_raw = lane_m;

  // Pick the addressed lanes out of the assembled word and extend them.
  always_comb begin
    ld_sh = ld_raw >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_sh[7]}},   ld_sh[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}},       ld_sh[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}},      ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // Sequencer: accept, issue beats, wait for read returns, write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wb_valid     <= 1'b0;
      rd_data_o    <= '0;
      rd_addr_o    <= '0;
      rd_we_o      <= 1'b0;
      exc_misalign <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      wd_sh        <= '0;
      beat         <= '0;
      last_beat    <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      rd_addr_q    <= '0;
      rd_we_q      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (!is_mem) begin
            wb_valid     <= 1'b1;
            rd_data_o    <= rd_data_i;
            rd_addr_o    <= rd_addr_i;
            rd_we_o      <= rd_we_i;
            exc_misalign <= 1'b0;
          end else if (mis) begin
            wb_valid     <= 1'b1;
            rd_data_o    <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            exc_misalign <= 1'b1;
          end else begin
            state     <= REQ;
            mem_we    <= is_store;
            mem_addr  <= addr_i & ~AMASK;
            mem_be    <= (sz > BB3) ? '1 : be8[BUS_BYTES-1:0];
            wd_sh     <= wdata_i << {off_i, 3'b000};
            beat      <= '0;
            last_beat <= nb_last;
            off_q     <= off_i;   // zero whenever the access spans several beats
            f3_q      <= funct3;
            rd_addr_q <= rd_addr_i;
            rd_we_q   <= rd_we_i;
          end
        end
        REQ: if (mem_gnt) begin
          if (!mem_we) begin
            state <= WAIT;
          end else if (beat == last_beat) begin
            state        <= DONE;
            wb_valid     <= 1'b1;
            rd_data_o    <= '0;
            rd_addr_o    <= '0;
            rd_we_o      <= 1'b0;
            exc_misalign <= 1'b0;
          end else begin
            beat     <= beat + 2'd1;
            mem_addr <= mem_addr + ABB;
            wd_sh    <= wd_sh >> BW;
          end
        end
        WAIT: if (mem_rvalid) begin
          if (beat == last_beat) begin
            state        <= DONE;
            wb_valid     <= 1'b1;
            rd_data_o    <= ld_ext;
            rd_addr_o    <= rd_addr_q;
            rd_we_o      <= rd_we_q;
            exc_misalign <= 1'b0;
          end else begin
            state    <= REQ;
            beat     <= beat + 2'd1;
            mem_addr <= mem_addr + ABB;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
